// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver with 16x oversampling derived from sysclk.
// Emits the received byte with a one-cycle valid pulse and flags bad stop bits.
module uart_rx_16x #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err
);

   localparam int unsigned TW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [3:0]  SC_MID    = 4'd7;
   localparam logic [3:0]  SC_END    = 4'd15;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state, state_d;
   logic          rx_m, rx_s;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [3:0]    sc, sc_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    shift, shift_d;
   logic [7:0]    rx_data_d;
   logic          rx_valid_d, rx_busy_d, frame_err_d;

   // Two-flop synchronizer and free-running oversample tick
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         tcnt <= '0;
      end else begin
         rx_m <= uart_rx;
         rx_s <= rx_m;
         tcnt <= tick ? '0 : tcnt + TW'(1);
      end
   end

   assign tick = (tcnt == TICK_LAST);

   always_ff @(posedge sysclk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (tick) begin
         case (state)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (sc == SC_MID) state_d = rx_s ? IDLE : DATA;
            DATA:      if (sc == SC_END && bit_idx == 3'd7) state_d = STOP;
            STOP:      if (sc == SC_END) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values; sampling happens only on tick cycles
   always_comb begin
      sc_d        = sc;
      bit_idx_d   = bit_idx;
      shift_d     = shift;
      rx_data_d   = rx_data;
      rx_valid_d  = 1'b0;
      frame_err_d = frame_err;
      rx_busy_d   = (state_d != IDLE);
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) sc_d = 4'd0;
            end
            START: begin
               if (sc == SC_MID) begin
                  sc_d      = 4'd0;
                  bit_idx_d = 3'd0;
               end else begin
                  sc_d = sc + 4'd1;
               end
            end
            DATA: begin
               if (sc == SC_END) begin
                  shift_d[bit_idx] = rx_s;
                  sc_d             = 4'd0;
                  bit_idx_d        = bit_idx + 3'd1;
               end else begin
                  sc_d = sc + 4'd1;
               end
            end
            STOP: begin
               if (sc == SC_END) begin
                  sc_d = 4'd0;
                  if (rx_s) begin
                     rx_data_d   = shift;
                     rx_valid_d  = 1'b1;
                     frame_err_d = 1'b0;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else begin
                  sc_d = sc + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sc        <= 4'd0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sc        <= sc_d;
         bit_idx   <= bit_idx_d;
         shift     <= shift_d;
         rx_data   <= rx_data_d;
         rx_valid  <= rx_valid_d;
         rx_busy   <= rx_busy_d;
         frame_err <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed + randomized bench for uart_rx_16x at DIV=4 (64 cycles per bit).
// Expected bytes come from a queue of frames the bench itself transmitted.
module tb_uart_rx_16x;

   localparam int unsigned BIT = 64;

   logic       sysclk  = 1'b0;
   logic       reset   = 1'b1;
   logic       uart_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err;

   int          checks = 0;
   int          fails  = 0;
   int unsigned cyc    = 0;

   logic [7:0]  got_q[$];
   int unsigned got_cyc_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  last_good = 8'h00;
   int          ferr_rises = 0;
   logic        ferr_prev = 1'b0;
   bit          burst = 1'b0;
   int          low_run = 0;
   int          low_max = 0;

   uart_rx_16x #(.CLK_FREQ(64_000_000), .BAUD(1_000_000)) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .uart_rx  (uart_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_busy  (rx_busy),
      .frame_err(frame_err)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   // Observe outputs on the falling edge
   always @(negedge sysclk) begin
      if (rx_valid) begin
         got_q.push_back(rx_data);
         got_cyc_q.push_back(cyc);
      end
      if (frame_err && !ferr_prev) ferr_rises++;
      ferr_prev = frame_err;
      if (burst && !rx_busy) begin
         low_run++;
         if (low_run > low_max) low_max = low_run;
      end else begin
         low_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int unsigned n);
      uart_rx = v;
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_ok);
      logic [9:0] frame;
      frame = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) drive(frame[i], BIT);
      if (stop_ok) begin
         exp_q.push_back(b);
         last_good = b;
      end
   endtask

   task automatic check_frames(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      got_q.delete();
      got_cyc_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned t0;
      int unsigned lat;
      logic [7:0]  b;
      logic [7:0]  partial;

      repeat (3) @(posedge sysclk);
      #1;
      check("rst_data",  {24'h0, rx_data}, 32'h0);
      check("rst_valid", {31'h0, rx_valid}, 32'h0);
      check("rst_busy",  {31'h0, rx_busy}, 32'h0);
      check("rst_ferr",  {31'h0, frame_err}, 32'h0);
      reset = 1'b0;
      drive(1'b1, 100);

      // Single frame with latency measured from the start edge
      t0 = cyc;
      send(8'hA5, 1'b1);
      drive(1'b1, BIT);
      lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - t0 : 0;
      check("a5_lat_window", {31'h0, (lat >= 600 && lat <= 616)}, 32'h1);
      check("a5_ferr", {31'h0, frame_err}, 32'h0);
      check_frames("a5");

      // Back-to-back frames, no idle gap between stop and next start
      burst = 1'b1;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h3C, 1'b1);
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1);
      burst = 1'b0;
      drive(1'b1, BIT);
      check("b2b_idle_short", {31'h0, (low_max > 0 && low_max < int'(BIT))}, 32'h1);
      check("b2b_busy_end", {31'h0, rx_busy}, 32'h0);
      check_frames("b2b");

      // Start glitch of 5 ticks is rejected at mid start bit
      drive(1'b0, 20);
      drive(1'b1, BIT - 20);
      check("glitch_busy", {31'h0, rx_busy}, 32'h0);
      check("glitch_data", {24'h0, rx_data}, {24'h0, last_good});
      drive(1'b1, BIT);
      check_frames("glitch");

      // Bad stop bit followed by a held-low break
      ferr_rises = 0;
      send(8'h55, 1'b0);
      drive(1'b0, 3 * BIT);
      check("brk_ferr", {31'h0, frame_err}, 32'h1);
      check("brk_busy", {31'h0, rx_busy}, 32'h1);
      check("brk_data", {24'h0, rx_data}, {24'h0, last_good});
      check("brk_single_err", ferr_rises, 32'd1);
      check_frames("brk");
      drive(1'b1, BIT);
      send(8'h81, 1'b1);
      drive(1'b1, BIT);
      check("post_brk_ferr", {31'h0, frame_err}, 32'h0);
      check("post_brk_data", {24'h0, rx_data}, 32'h81);
      check_frames("post_brk");

      // Reset in the middle of the data bits of 0x7E
      partial = 8'h7E;
      drive(1'b0, BIT);
      for (int i = 0; i < 3; i++) drive(partial[i], BIT);
      drive(partial[3], BIT / 2);
      reset = 1'b1;
      @(posedge sysclk);
      #1;
      reset = 1'b0;
      uart_rx = 1'b1;
      last_good = 8'h00;
      check("mid_rst_data",  {24'h0, rx_data}, 32'h0);
      check("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
      check("mid_rst_busy",  {31'h0, rx_busy}, 32'h0);
      check("mid_rst_ferr",  {31'h0, frame_err}, 32'h0);
      drive(1'b1, 2 * BIT);
      check("mid_rst_data_hold", {24'h0, rx_data}, 32'h0);
      check_frames("mid_rst");
      send(8'h12, 1'b1);
      drive(1'b1, BIT);
      check("after_rst_data", {24'h0, rx_data}, 32'h12);
      check_frames("after_rst");

      // Random bytes at random tick phases and gaps
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send(b, 1'b1);
         drive(1'b1, 1 + $urandom_range(0, 40));
      end
      drive(1'b1, BIT);
      check("rand_ferr", {31'h0, frame_err}, 32'h0);
      check("rand_last", {24'h0, rx_data}, {24'h0, last_good});
      check_frames("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
